// File: rtl/trace_checker.sv
`default_nettype none
// ============================================================================
// Module   : trace_checker
// Purpose  : Compares the DUT retirement stream against a golden trace.
//            Retirements are buffered in a small FIFO and checked one by one
//            against golden records; the run ends in PASS or FAIL.
// Options  : TRACE_CHK_TIMEOUT_EN - enables the no-retirement timeout.
// Revision : 1.0 - initial release
// ============================================================================
module trace_checker #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wb_have_inst,
  input  logic [31:0] wb_pc,
  input  logic        wb_ena,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_value,
  input  logic        gold_valid,
  output logic        gold_ready,
  input  logic [31:0] gold_pc,
  input  logic        gold_ena,
  input  logic [4:0]  gold_reg,
  input  logic [31:0] gold_value,
  input  logic        gold_last,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  fail_code,
  output logic [31:0] fail_pc,
  output logic [31:0] retired_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] CODE_MISMATCH = 2'd0;
  localparam logic [1:0] CODE_OVERFLOW = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Retirement FIFO storage, one array per record field
  logic [31:0] fifo_pc    [FIFO_DEPTH];
  logic        fifo_ena   [FIFO_DEPTH];
  logic [4:0]  fifo_reg   [FIFO_DEPTH];
  logic [31:0] fifo_value [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic        in_run, push, push_ok, cmp, head_match;
  logic        mismatch, overflow, good, timeout_hit;
  logic        err_set;
  logic [1:0]  err_code;
  logic [31:0] err_pc;

  // Datapath decode: push/compare strobes and record match
  always_comb begin
    in_run     = (state == ST_RUN);
    push       = in_run && wb_have_inst;
    cmp        = in_run && (count != '0) && gold_valid && !rst;
    head_match = (fifo_pc[rd_ptr] == gold_pc) &&
                 (fifo_ena[rd_ptr] == gold_ena) &&
                 (!fifo_ena[rd_ptr] || (fifo_reg[rd_ptr] == gold_reg)) &&
                 (!(fifo_ena[rd_ptr] && (fifo_reg[rd_ptr] != 5'd0)) ||
                  (fifo_value[rd_ptr] == gold_value));
    mismatch   = cmp && !head_match;
    good       = cmp && head_match;
    // A simultaneous pop makes room, so only an un-popped full push overflows
    overflow   = push && (count == DEPTH_C) && !cmp;
    push_ok    = push && !overflow;
    gold_ready = cmp;
  end

`ifdef TRACE_CHK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  // Idle-cycle counter: cleared by start and every push, counts quiet RUN cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (((state == ST_IDLE) && start) || push) begin
      to_cnt <= '0;
    end else if (in_run) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // Fires on the quiet cycle that would bring the count to TIMEOUT_CYC
  assign timeout_hit = in_run && !push && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  // No counter in this build; the comparison is constant false for any legal TIMEOUT_CYC
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  // Next-state and error selection; mismatch outranks overflow outranks timeout
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_code  = CODE_MISMATCH;
    err_pc    = 32'd0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (mismatch) begin
          err_set  = 1'b1;
          err_code = CODE_MISMATCH;
          err_pc   = fifo_pc[rd_ptr];
        end else if (overflow) begin
          err_set  = 1'b1;
          err_code = CODE_OVERFLOW;
          err_pc   = wb_pc;
        end else if (timeout_hit) begin
          err_set  = 1'b1;
          err_code = CODE_TIMEOUT;
          err_pc   = 32'd0;
        end
        if (err_set)               state_nxt = ST_FAIL;
        else if (good && gold_last) state_nxt = ST_PASS;
      end
      default: state_nxt = state;
    endcase
  end

  // State, verdict and error-report registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'd0;
      fail_pc   <= 32'd0;
    end else begin
      state <= state_nxt;
      pass  <= (state_nxt == ST_PASS);
      fail  <= (state_nxt == ST_FAIL);
      if (err_set) begin
        fail_code <= err_code;
        fail_pc   <= err_pc;
      end
    end
  end

  // Saturating count of matched comparisons
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= 32'd0;
    end else if (good && (retired_cnt != 32'hFFFF_FFFF)) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (cmp)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, cmp})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write; contents need no reset since occupancy guards reads
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_pc[wr_ptr]    <= wb_pc;
      fifo_ena[wr_ptr]   <= wb_ena;
      fifo_reg[wr_ptr]   <= wb_reg;
      fifo_value[wr_ptr] <= wb_value;
    end
  end

endmodule
`default_nettype wire
